icache_line_fetcher: RTL and testbench
======================================

// Module: icache_line_fetcher
// PURPOSE
//  Memory-side refill engine for the instruction cache. Accepts one line-fetch request (fc_ena/fc_addr),
//  wins the shared byte-wide RAM bus through a req/gnt arbiter, reads 16 consecutive bytes and returns
//  a 128-bit little-endian line with a one-cycle fc_done pulse. Sits between icache and RAM bus arbiter.
// PARAMETERS
//  LINE_BYTES  16  bytes per cache line; fc_line width = 8*LINE_BYTES; must be a power of two
//  ADDR_W      32  byte-address width
// PORTS
//  clk       in   1    single clock, all state on rising edge
//  rst_n     in   1    reset, asynchronous, active-low
//  rdy       in   1    global ready; low = freeze all state, outputs hold
//  abort     in   1    rollback/flush; cancels any fetch in progress
//  fc_ena    in   1    icache refill request, level, held until fc_done seen
//  fc_addr   in   32   refill address; bits [3:0] ignored (line-aligned internally)
//  fc_done   out  1    one-cycle pulse, fc_line valid in same cycle
//  fc_line   out  128  assembled line; byte i at [8i+7:8i]; holds until next done
//  bus_req   out  1    request for RAM bus
//  bus_gnt   in   1    grant from arbiter; sampled only while bus_req high
//  mem_a     out  32   RAM byte address
//  mem_wr    out  1    RAM write enable; constant 0
//  mem_dout  out  8    RAM write data; constant 0
//  mem_din   in   8    RAM read data, valid the cycle after mem_a is presented
// BEHAVIOUR
//  Reset (rst_n=0, immediate): state IDLE; fc_done, fc_line, bus_req, mem_a, counters = 0.
//  rdy=0: no state/counter/register update; abort also ignored while rdy=0.
//  States:
//   IDLE  : fc_ena && !abort -> latch base={fc_addr[31:4],4'b0}, bus_req<=1, -> WAIT_GNT.
//   WAIT_GNT: bus_gnt -> cnt<=0, -> READ. bus_req stays 1.
//   READ  : cycle t=0..16 after grant edge. For t<=15 mem_a=base+t (combinational from cnt).
//           At end of cycle t>=1, mem_din stored as byte t-1. After t=16 edge: fc_line<=assembled,
//           fc_done<=1, bus_req<=0, -> DONE. Bus held 17 cycles; mem_a=0 outside READ.
//   DONE  : fc_done high exactly this cycle; -> DRAIN.
//   DRAIN : wait until fc_ena==0, then -> IDLE (prevents re-issue on the stale request).
//  Latency: grant edge E0 -> fc_done high in the 18th cycle after E0, no stalls.
//  abort (rdy=1) in WAIT_GNT/READ: -> IDLE next edge, bus_req<=0, no fc_done, fc_line unchanged.
//  abort on the t=16 cycle: abort wins, no done. abort in DONE/DRAIN: -> IDLE, done pulse not extended.
//  fc_ena falling mid-fetch without abort: fetch completes, fc_done still pulsed, DRAIN exits at once.
//  bus_gnt dropping during READ is a protocol violation (arbiter holds gnt while req high); not handled.
//  Address arithmetic: base+t wraps modulo 2^32; base line-aligned so no carry beyond bit 3.
//  cnt width = log2(LINE_BYTES)+1.
// STRUCTURE
//  Shared constants in utils.v: ADDR_TP, LINE_TP, LINE_LN, TRUE/FALSE; add BYTE_TP (7:0).
//  State encoding is local (localparam).
//  Single module, no sub-module; byte assembly as an indexed write into a line register.
// TESTING
//  1 Basic: RAM[0x1000+i]=i+0x10, fc_addr=0x1004, gnt 2 cycles after req -> mem_a 0x1000..0x100F,
//    fc_line=0x1F1E..1110, one fc_done pulse at 18th cycle after grant edge.
//  2 Hold request: fc_ena kept high 3 cycles after done -> no second bus_req until fc_ena low.
//  3 Abort at t=7 -> bus_req drops next edge, no fc_done, fc_line retains prior value.
//  4 rdy low 5 cycles at t=4 -> mem_a held at base+4, bytes correct, done delayed exactly 5 cycles.
//  5 Delayed grant: gnt withheld 20 cycles -> mem_a stays 0, bus_req held, fetch then completes normally.
//  6 Async reset asserted mid-READ (between edges) -> bus_req, fc_done 0 immediately; clean refetch after.

Source files
------------

// File: rtl/icache_line_fetcher_pkg.sv
// Shared types and constants for the instruction-cache line fetcher.
//   byte_tp  : one RAM bus byte
//   LINE_LN  : default bytes per cache line
//   ADDR_LN  : default byte-address width
//   TRUE/FALSE : single-bit control constants
package icache_line_fetcher_pkg;

  typedef logic [7:0] byte_tp;

  localparam int   LINE_LN = 16;
  localparam int   ADDR_LN = 32;
  localparam logic TRUE    = 1'b1;
  localparam logic FALSE   = 1'b0;

endpackage

// File: rtl/icache_line_fetcher.sv
// Memory-side refill engine for the instruction cache. Takes one line-fetch
// request, wins the shared byte-wide RAM bus through a req/gnt handshake,
// reads LINE_BYTES consecutive bytes and returns a little-endian line with a
// one-cycle done pulse.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   rdy              global ready; low freezes every register
//   abort            cancels a fetch in progress
//   fc_ena, fc_addr  refill request (level) and address (low bits ignored)
//   fc_done, fc_line one-cycle completion pulse and assembled line
//   bus_req, bus_gnt RAM bus arbitration
//   mem_a, mem_wr, mem_dout, mem_din   byte-wide RAM interface (read only)
module icache_line_fetcher
  import icache_line_fetcher_pkg::*;
#(
  parameter int LINE_BYTES = LINE_LN,
  parameter int ADDR_W     = ADDR_LN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic                    abort,
  input  logic                    fc_ena,
  input  logic [ADDR_W-1:0]       fc_addr,
  output logic                    fc_done,
  output logic [8*LINE_BYTES-1:0] fc_line,
  output logic                    bus_req,
  input  logic                    bus_gnt,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  output logic [7:0]              mem_dout,
  input  logic [7:0]              mem_din
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_BYTES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]                state;
  logic [CNT_W-1:0]          cnt;
  logic [ADDR_W-OFF_W-1:0]   line_addr;
  byte_tp [LINE_BYTES-2:0]   line_buf;
  byte_tp [LINE_BYTES-1:0]   line_asm;
  logic [OFF_W-1:0]          wr_idx;
  logic                      at_end;
  logic                      start;
  logic                      unused_low;

  // Offset bits of the request address are dropped: fetches are line-aligned.
  assign unused_low = &{1'b0, fc_addr[OFF_W-1:0]};

  assign start  = (state == S_IDLE) && fc_ena && !abort;
  assign at_end = (cnt == CNT_LAST);
  // Byte presented at count t-1 arrives on mem_din during count t.
  assign wr_idx = OFF_W'(cnt - 1'b1);

  // Line base is aligned, so the offset is a concatenation rather than an add.
  assign mem_a    = (state == S_READ && !at_end) ? {line_addr, cnt[OFF_W-1:0]} : '0;
  assign mem_wr   = FALSE;
  assign mem_dout = '0;

  // The last byte is never parked in line_buf; it goes straight into the line.
  always_comb begin
    line_asm = {mem_din, line_buf};
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bus_req <= FALSE;
      fc_done <= FALSE;
      fc_line <= '0;
    end else if (rdy) begin
      fc_done <= FALSE;
      case (state)
        S_IDLE: begin
          if (start) begin
            bus_req <= TRUE;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            bus_req <= FALSE;
            state   <= S_IDLE;
          end else if (bus_gnt) begin
            cnt   <= '0;
            state <= S_READ;
          end
        end
        S_READ: begin
          if (abort) begin
            bus_req <= FALSE;
            state   <= S_IDLE;
          end else if (at_end) begin
            fc_line <= line_asm;
            fc_done <= TRUE;
            bus_req <= FALSE;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= abort ? S_IDLE : S_DRAIN;
        end
        S_DRAIN: begin
          // Hold here until the icache drops its request so a stale level
          // request does not trigger a second refill.
          if (abort || !fc_ena) state <= S_IDLE;
        end
        default: begin
          bus_req <= FALSE;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Data capture
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (start) line_addr <= fc_addr[ADDR_W-1:OFF_W];
      if (state == S_READ && cnt != '0 && !at_end) line_buf[wr_idx] <= mem_din;
    end
  end

endmodule

// File: tb/tb_icache_line_fetcher.sv
// Self-checking bench for icache_line_fetcher: a table of refill requests
// driven through a shared task, plus hand-written sequences for abort,
// request drop mid-fetch and asynchronous reset. Expected lines are queued
// when a request is issued and compared when fc_done pulses.
module tb_icache_line_fetcher;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rdy = 1'b1;
  logic         abort = 1'b0;
  logic         fc_ena = 1'b0;
  logic [31:0]  fc_addr = '0;
  logic         fc_done;
  logic [127:0] fc_line;
  logic         bus_req;
  logic         bus_gnt = 1'b0;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic [7:0]   mem_dout;
  logic [7:0]   mem_din = '0;

  int total = 0;
  int bad = 0;
  int gnt_delay = 0;
  logic [127:0] sb[$];

  always #5 clk = ~clk;

  icache_line_fetcher dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .abort(abort),
    .fc_ena(fc_ena), .fc_addr(fc_addr), .fc_done(fc_done), .fc_line(fc_line),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .mem_a(mem_a), .mem_wr(mem_wr),
    .mem_dout(mem_dout), .mem_din(mem_din)
  );

  function automatic logic [7:0] ram(input logic [31:0] a);
    return a[7:0] + 8'h10 + a[23:16];
  endfunction

  function automatic logic [127:0] line_model(input logic [31:0] addr);
    logic [127:0] l;
    logic [31:0]  b;
    b = {addr[31:4], 4'h0};
    for (int i = 0; i < 16; i++) l[8*i +: 8] = ram(b + 32'(i));
    return l;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic give_up(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  endtask

  // RAM (one-cycle read latency, frozen by rdy) and arbiter responder.
  initial begin
    logic [31:0] last_a;
    int gcnt;
    last_a = '0;
    gcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rdy) begin
        mem_din = ram(last_a);
        last_a  = mem_a;
      end
      if (!bus_req) gcnt = 0;
      else if (rdy) gcnt++;
      bus_gnt = bus_req && (gcnt > gnt_delay);
    end
  end

  // Scoreboard consumer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && fc_done === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done with line %0h, expected no done", fc_line);
        end else begin
          check("line", fc_line, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #3000000;
    give_up("watchdog");
  end

  // Wait (bounded) for the cycle in which the grant is visible; the next
  // rising edge is the grant edge. Returns any nonzero mem_a seen meanwhile.
  task automatic wait_grant(input string name, output logic [31:0] stray_a);
    int n;
    n = 0;
    stray_a = '0;
    do begin
      @(negedge clk);
      n++;
      if (mem_a !== 32'h0 && stray_a == 32'h0) stray_a = mem_a;
    end while (!(bus_req === 1'b1 && bus_gnt === 1'b1) && n < 200);
    if (n >= 200) give_up(name);
  endtask

  task automatic fetch(input logic [31:0] addr, input int dly, input int hold,
                       input int stall_at, input int stall_len, input logic [127:0] exp);
    logic [31:0] base, want, stray;
    int errs, herr;
    base = {addr[31:4], 4'h0};
    gnt_delay = dly;
    errs = 0;
    herr = 0;
    @(posedge clk);
    #1 fc_ena = 1'b1;
    fc_addr = addr;
    sb.push_back(exp);
    wait_grant("grant", stray);
    check("wait_mem_a", stray, 32'h0);
    @(posedge clk);
    for (int t = 0; t <= 16; t++) begin
      want = (t <= 15) ? base + 32'(t) : 32'h0;
      if (t == stall_at) begin
        #1 rdy = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          if (mem_a !== want || fc_done !== 1'b0) errs++;
          if (k < stall_len - 1) @(posedge clk);
        end
        @(posedge clk);
        #1 rdy = 1'b1;
      end
      @(negedge clk);
      if (mem_a !== want || fc_done !== 1'b0) errs++;
      @(posedge clk);
    end
    @(negedge clk);
    check("done_latency", fc_done, 1'b1);
    check("mem_a_seq_errs", errs, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_req !== 1'b0 || fc_done !== 1'b0) herr++;
    end
    if (hold > 0) check("hold_no_req", herr, 0);
    @(posedge clk);
    #1 fc_ena = 1'b0;
    check("sb_drained", sb.size(), 0);
  endtask

  // Start a fetch that is expected never to complete; returns at the start of count t.
  task automatic start_to(input logic [31:0] addr, input int t);
    logic [31:0] stray;
    gnt_delay = 1;
    @(posedge clk);
    #1 fc_ena = 1'b1;
    fc_addr = addr;
    wait_grant("grant_abort", stray);
    @(posedge clk);
    repeat (t) @(posedge clk);
  endtask

  typedef struct {
    logic [31:0]  addr;
    int           dly;
    int           hold;
    int           stall_at;
    int           stall_len;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [127:0] prev;
    int dcount;

    vecs[0] = '{32'h0000_1004, 2, 3, -1, 0, 128'h1F1E1D1C1B1A19181716151413121110};
    vecs[1] = '{32'h0002_35A0, 0, 0, -1, 0, line_model(32'h0002_35A0)};
    vecs[2] = '{32'hFFFF_FFF7, 1, 0, -1, 0, line_model(32'hFFFF_FFF7)};
    vecs[3] = '{32'h00AB_4010, 1, 1,  4, 5, line_model(32'h00AB_4010)};
    vecs[4] = '{32'h1234_5678, 20, 0, -1, 0, line_model(32'h1234_5678)};
    vecs[5] = '{32'h0000_0000, 3, 0, -1, 0, line_model(32'h0000_0000)};

    // Reset state
    @(negedge clk);
    check("rst_done", fc_done, 1'b0);
    check("rst_line", fc_line, 128'h0);
    check("rst_req", bus_req, 1'b0);
    check("rst_mem_a", mem_a, 32'h0);
    check("mem_wr", mem_wr, 1'b0);
    check("mem_dout", mem_dout, 8'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    foreach (vecs[i])
      fetch(vecs[i].addr, vecs[i].dly, vecs[i].hold, vecs[i].stall_at, vecs[i].stall_len, vecs[i].exp);

    // Abort at count 7
    prev = fc_line;
    start_to(32'h0000_2000, 7);
    #1 abort = 1'b1;
    fc_ena = 1'b0;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort7_req", bus_req, 1'b0);
    check("abort7_mem_a", mem_a, 32'h0);
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (fc_done === 1'b1) dcount++;
    end
    check("abort7_no_done", dcount, 0);
    check("abort7_line_kept", fc_line, prev);

    // Abort on the final count wins over completion
    start_to(32'h0000_2100, 16);
    #1 abort = 1'b1;
    fc_ena = 1'b0;
    @(posedge clk);
    #1 abort = 1'b0;
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (fc_done === 1'b1) dcount++;
    end
    check("abort16_no_done", dcount, 0);
    check("abort16_line_kept", fc_line, prev);

    // Request dropped mid-fetch: still completes, then returns to idle
    sb.push_back(line_model(32'h0000_5550));
    start_to(32'h0000_5550, 3);
    #1 fc_ena = 1'b0;
    dcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (fc_done === 1'b1) dcount++;
    end
    check("drop_done_count", dcount, 1);
    check("drop_req_idle", bus_req, 1'b0);
    check("drop_sb_drained", sb.size(), 0);

    // Asynchronous reset between edges during READ
    start_to(32'h0000_3000, 5);
    #3 rst_n = 1'b0;
    #1;
    check("arst_req", bus_req, 1'b0);
    check("arst_done", fc_done, 1'b0);
    check("arst_mem_a", mem_a, 32'h0);
    check("arst_line", fc_line, 128'h0);
    fc_ena = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    fetch(32'h0000_3000, 2, 0, -1, 0, line_model(32'h0000_3000));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
